lfsr_prpg_gen: RTL and testbench

- Parametrised pseudo-random pattern generator and successor to the fixed 4-bit PRPG.
- Provides N-bit width, programmable feedback taps, a step enable, zero-seed lock-up protection, full-period detection and a step counter.
- Feeds BIST stimulus and scrambler seeds.
- Outputs `num` (parallel word) and `sequence` (serial bit) in the clk domain.

---
 rtl/prpg_pkg.sv | 64 ++++++
 rtl/prpg_step.sv | 30 +++
 rtl/lfsr_prpg_gen.sv | 109 ++++++++++
 tb/tb_lfsr_prpg_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/prpg_pkg.sv
// ============================================================================
// Module      : prpg_pkg
// Description : Shared types, default maximal tap tables and the zero-seed fix
//               for the lfsr_prpg_gen pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prpg_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } prpg_state_e;

  // Fibonacci masks: bit i set means state bit i feeds the XOR (MSB always set).
  function automatic logic [31:0] fib_taps(input int unsigned n);
    case (n)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return (32'h1 << (n - 1)) | (32'h1 << (n - 2));
    endcase
  endfunction

  // Galois masks hold the polynomial's low-order coefficients (x^N implied).
  function automatic logic [31:0] galois_taps(input int unsigned n);
    case (n)
      3:       return 32'h0000_0003;
      4:       return 32'h0000_0003;
      5:       return 32'h0000_0005;
      6:       return 32'h0000_0003;
      7:       return 32'h0000_0003;
      8:       return 32'h0000_001D;
      9:       return 32'h0000_0011;
      10:      return 32'h0000_0009;
      11:      return 32'h0000_0005;
      12:      return 32'h0000_0053;
      13:      return 32'h0000_001B;
      14:      return 32'h0000_0443;
      15:      return 32'h0000_0003;
      16:      return 32'h0000_100B;
      default: return 32'h0000_0003;
    endcase
  endfunction

  function automatic logic [31:0] zero_fix(input logic [31:0] seed);
    return (seed == 32'h0) ? 32'h1 : seed;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prpg_step.sv
// ============================================================================
// Module      : prpg_step
// Description : Combinational next-state function of the LFSR. Fibonacci form
//               by default, Galois form when PRPG_GALOIS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prpg_step
  import prpg_pkg::*;
#(
  parameter int             N     = 4,
  parameter logic [N-1:0]   TAPS  = N'(fib_taps(N))
`ifdef PRPG_GALOIS_EN
  , parameter logic [N-1:0] GTAPS = N'(galois_taps(N))
`endif
) (
  input  logic [N-1:0] num,
  output logic [N-1:0] next_state
);

`ifdef PRPG_GALOIS_EN
  assign next_state = {num[N-2:0], 1'b0} ^ (num[N-1] ? GTAPS : {N{1'b0}});
`else
  assign next_state = {num[N-2:0], ^(num & TAPS)};
`endif

endmodule

`default_nettype wire

// File: rtl/lfsr_prpg_gen.sv
// ============================================================================
// Module      : lfsr_prpg_gen
// Description : Parametrised LFSR pattern generator with seed load, zero-seed
//               protection, period detection and step counter. Define
//               PRPG_GALOIS_EN for the Galois step form (adds GTAPS).
//               The serial output is named seq since sequence is reserved.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_prpg_gen
  import prpg_pkg::*;
#(
  parameter int             N         = 4,
  parameter logic [N-1:0]   TAPS      = N'(fib_taps(N)),
  parameter logic [N-1:0]   RESET_VAL = {N{1'b1}}
`ifdef PRPG_GALOIS_EN
  , parameter logic [N-1:0] GTAPS     = N'(galois_taps(N))
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] seed,
  input  logic         load,
  input  logic         en,
  output logic [N-1:0] num,
  output logic         seq,
  output logic [N-1:0] count,
  output logic         valid,
  output logic         period_done,
  output logic         seed_err
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]   r_state;
  logic [N-1:0] r_num;
  logic [N-1:0] r_seed;
  logic [N-1:0] r_count;
  logic         r_valid;
  logic         r_period;
  logic         r_err;

  logic [N-1:0] w_next;
  logic [N-1:0] w_seed_fix;
  logic         w_seed_zero;
  logic         w_step;
  logic         w_wrap;

  prpg_step #(
    .N     (N),
    .TAPS  (TAPS)
`ifdef PRPG_GALOIS_EN
    , .GTAPS (GTAPS)
`endif
  ) u_step (
    .num        (r_num),
    .next_state (w_next)
  );

  assign w_seed_zero = (seed == {N{1'b0}});
  assign w_seed_fix  = N'(zero_fix(32'(seed)));
  assign w_step      = (r_state == ST_RUN) && en && !load;
  // Returning to the stored seed closes one full period.
  assign w_wrap      = (w_next == r_seed);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_num    <= RESET_VAL;
      r_seed   <= RESET_VAL;
      r_count  <= {N{1'b0}};
      r_valid  <= 1'b0;
      r_period <= 1'b0;
      r_err    <= 1'b0;
    end else if (load) begin
      r_state  <= ST_RUN;
      r_num    <= w_seed_fix;
      r_seed   <= w_seed_fix;
      r_count  <= {N{1'b0}};
      r_valid  <= 1'b1;
      r_period <= 1'b0;
      r_err    <= w_seed_zero;
    end else begin
      r_period <= 1'b0;
      r_err    <= 1'b0;
      if (w_step) begin
        r_num <= w_next;
        if (w_wrap) begin
          r_count  <= {N{1'b0}};
          r_period <= 1'b1;
        end else begin
          r_count  <= r_count + N'(1);
        end
      end
    end
  end

  assign num         = r_num;
  assign seq         = r_num[N-1];
  assign count       = r_count;
  assign valid       = r_valid;
  assign period_done = r_period;
  assign seed_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_prpg_gen.sv
// ============================================================================
// Module      : tb_lfsr_prpg_gen
// Description : Self-checking bench for lfsr_prpg_gen (N=4) with a polynomial
//               reference model, directed literals and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lfsr_prpg_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] seed = 4'h0;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic [3:0] num;
  logic       seq;
  logic [3:0] count;
  logic       valid;
  logic       period_done;
  logic       seed_err;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  logic [3:0] m_num, m_seed, m_count;
  logic       m_valid, m_pd, m_err, m_run;

  lfsr_prpg_gen dut (
    .clk         (clk),
    .reset       (reset),
    .seed        (seed),
    .load        (load),
    .en          (en),
    .num         (num),
    .seq         (seq),
    .count       (count),
    .valid       (valid),
    .period_done (period_done),
    .seed_err    (seed_err)
  );

  always #5 clk = ~clk;

  // Multiplication by x in GF(2)[x] modulo the generator polynomial.
  function automatic logic [3:0] model_next(input logic [3:0] s);
`ifdef PRPG_GALOIS_EN
    return {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
`else
    return {s[2:0], s[3] ^ s[2]};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_num <= 4'hF; m_seed <= 4'hF; m_count <= 4'h0;
      m_valid <= 1'b0; m_pd <= 1'b0; m_err <= 1'b0; m_run <= 1'b0;
    end else if (load) begin
      m_num   <= (seed == 4'h0) ? 4'h1 : seed;
      m_seed  <= (seed == 4'h0) ? 4'h1 : seed;
      m_count <= 4'h0;
      m_valid <= 1'b1;
      m_pd    <= 1'b0;
      m_err   <= (seed == 4'h0);
      m_run   <= 1'b1;
    end else begin
      m_pd  <= 1'b0;
      m_err <= 1'b0;
      if (m_run && en) begin
        m_num <= model_next(m_num);
        if (model_next(m_num) == m_seed) begin
          m_count <= 4'h0;
          m_pd    <= 1'b1;
        end else begin
          m_count <= m_count + 4'h1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_num", num, m_num);
      check("model_seq", seq, m_num[3]);
      check("model_count", count, m_count);
      check("model_valid", valid, m_valid);
      check("model_period_done", period_done, m_pd);
      check("model_seed_err", seed_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef PRPG_GALOIS_EN
  logic [3:0] exp_seq [15] = '{4'hD, 4'h9, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6,
                               4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE, 4'hF};
  logic [3:0] exp_a [3] = '{4'h7, 4'hE, 4'hF};
`else
  logic [3:0] exp_seq [15] = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                               4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
  logic [3:0] exp_a [3] = '{4'h5, 4'hB, 4'h7};
`endif

  initial begin
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    check("reset_num", num, 4'hF);
    check("reset_count", count, 4'h0);
    check("reset_valid", valid, 1'b0);
    check("reset_seq", seq, 1'b1);
    check("reset_pulses", {period_done, seed_err}, 2'b00);

    // Enable without a load must not move the state.
    en = 1'b1;
    repeat (3) tick();
    check("idle_num", num, 4'hF);
    check("idle_valid", valid, 1'b0);
    check("idle_count", count, 4'h0);

    load = 1'b1; seed = 4'hF; en = 1'b0;
    tick();
    load = 1'b0;
    check("load_f_num", num, 4'hF);
    check("load_f_valid", valid, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("seq_num", num, exp_seq[i]);
      check("seq_count", count, (i == 14) ? 0 : i + 1);
      check("seq_period", period_done, (i == 14) ? 1 : 0);
    end

    load = 1'b1; seed = 4'h0; en = 1'b0;
    tick();
    load = 1'b0;
    check("zero_num", num, 4'h1);
    check("zero_err", seed_err, 1'b1);
    check("zero_valid", valid, 1'b1);
    en = 1'b1;
    tick();
    check("zero_err_drop", seed_err, 1'b0);
    for (int i = 1; i < 15; i++) begin
      tick();
      check("zero_period", period_done, (i == 14) ? 1 : 0);
    end
    check("zero_wrap_num", num, 4'h1);

    load = 1'b1; seed = 4'hA; en = 1'b1;
    tick();
    load = 1'b0;
    check("load_en_num", num, 4'hA);
    check("load_en_count", count, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_num", num, exp_a[i]);
    end
    en = 1'b0;
    repeat (2) tick();
    check("hold_num", num, exp_a[2]);
    check("hold_count", count, 4'h3);

    load = 1'b1; seed = 4'hF;
    tick();
    load = 1'b0; en = 1'b1;
    repeat (7) tick();
    #2 reset = 1'b0;
    #1;
    check("async_num", num, 4'hF);
    check("async_count", count, 4'h0);
    check("async_valid", valid, 1'b0);
    check("async_pulses", {period_done, seed_err}, 2'b00);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    check("post_reset_valid", valid, 1'b0);
    check("post_reset_num", num, 4'hF);

    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 11) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      en   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 79) == 0) begin
        #1 reset = 1'b0;
        #4 reset = 1'b1;
      end
      tick();
    end

    load = 1'b0; en = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
